// File: rtl/instr_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, drives the synchronous ROM and
// buffers returned words in a small FIFO for decode. Optional macro: FETCH_EARLY_JMP_EN.
module instr_fetch_unit #(
  parameter logic [9:0] RESET_PC   = 10'h000,
  parameter int         FIFO_DEPTH = 2,        // 2 or 4
  parameter logic [5:0] JMP_OPCODE = 6'h0F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic [9:0]  pc,
  input  logic [15:0] instr_in,
  output logic        instr_valid,
  output logic [15:0] instr_out,
  output logic [9:0]  instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [9:0]  redirect_pc
);

  localparam int PW = (FIFO_DEPTH > 2) ? 2 : 1;
  localparam int CW = 3;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
`ifdef FETCH_EARLY_JMP_EN
  localparam logic EARLY_JMP = 1'b1;
`else
  localparam logic EARLY_JMP = 1'b0;
`endif

  logic [9:0]  fetch_pc_q, fetch_pc_d;
  logic [9:0]  tag_q, tag_d;
  logic        inflight_q, inflight_d;
  logic        discard_q, discard_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH-1:0][15:0] fifo_instr_q, fifo_instr_d;
  logic [FIFO_DEPTH-1:0][9:0]  fifo_pc_q, fifo_pc_d;

  logic          pop, push, issue, jmp_take;
  logic [CW-1:0] occ, limit;

  assign instr_valid = (count_q != '0);
  assign instr_out   = instr_valid ? fifo_instr_q[rd_ptr_q] : 16'h0000;
  assign instr_pc    = instr_valid ? fifo_pc_q[rd_ptr_q] : 10'h000;
  assign pc          = fetch_pc_q;

  always_comb begin
    pop      = instr_valid & instr_ready & ~redirect_valid;
    push     = inflight_q & ~discard_q & ~redirect_valid;
    // count + inflight - pop < DEPTH, rearranged to avoid unsigned underflow
    occ      = count_q + {{(CW-1){1'b0}}, inflight_q};
    limit    = DEPTH_C + {{(CW-1){1'b0}}, pop};
    issue    = run & ~redirect_valid & (occ < limit);
    jmp_take = EARLY_JMP & push & (instr_in[15:10] == JMP_OPCODE);

    fetch_pc_d = fetch_pc_q;
    if (redirect_valid)  fetch_pc_d = redirect_pc;
    else if (jmp_take)   fetch_pc_d = instr_in[9:0];
    else if (issue)      fetch_pc_d = fetch_pc_q + 10'd1;

    inflight_d = issue;
    tag_d      = issue ? fetch_pc_q : tag_q;
    // the sequential successor issued alongside a taken jump is dead on return
    discard_d  = jmp_take & issue;

    fifo_instr_d = fifo_instr_q;
    fifo_pc_d    = fifo_pc_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    if (redirect_valid) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        fifo_instr_d[wr_ptr_q] = instr_in;
        fifo_pc_d[wr_ptr_q]    = tag_q;
        wr_ptr_d               = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      tag_q      <= '0;
      inflight_q <= 1'b0;
      discard_q  <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Storage is only observed through count/pointers, so it needs no reset.
  always_ff @(posedge clk) begin
    fifo_instr_q <= fifo_instr_d;
    fifo_pc_q    <= fifo_pc_d;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction-fetch front end. It drives the program-counter address into the synchronous instruction ROM and collects each 16-bit instruction the ROM returns one cycle later.
- Presents instructions in order to decode over a valid/ready handshake, through a small FIFO.
- Owns the fetch PC: sequential increment, 10-bit wrap, flush and redirect on jumps from execute.

Parameters:
- RESET_PC, 10'h000, fetch address loaded on reset.
- FIFO_DEPTH, 2, decode-side buffer entries; legal values are 2 or 4 only.
- JMP_OPCODE, 6'h0F, opcode in instr[15:10] recognised as an unconditional jump (used only by the optional feature).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  fetch enable; 0 stops new ROM reads, buffered instructions still drain.
- pc  out  10  address to the ROM; registered (driven directly from fetch_pc).
- instr_in  in  16  ROM data; holds the word for the pc sampled at the previous posedge.
- instr_valid  out  1  FIFO head valid.
- instr_out  out  16  FIFO head instruction.
- instr_pc  out  10  address the head instruction was fetched from.
- instr_ready  in  1  decode accepts head this cycle.
- redirect_valid  in  1  execute-stage jump/flush request.
- redirect_pc  in  10  new fetch address.

Behaviour:
- Reset: fetch_pc=RESET_PC, so pc=RESET_PC. FIFO empty, instr_valid=0, instr_out=16'h0000 (NOP), instr_pc=0, inflight=0, discard=0.
- Definitions:
  - pop = instr_valid & instr_ready & !redirect_valid.
  - issue = run & !redirect_valid & (count + inflight − pop < FIFO_DEPTH).
- On issue: inflight<=1 (tag = current fetch_pc) and fetch_pc<=fetch_pc+1, wrapping 10'h3FF→10'h000. No issue: inflight<=0 and fetch_pc holds.
- Return: if inflight & !discard & !redirect_valid, push {instr_in, tag} into the FIFO in that cycle. The FIFO can never be full at a push, because the issue rule prevents it.
- Latency:
  - pc=A in cycle N → instr_valid with instr_pc=A no earlier than cycle N+2.
  - Sustained throughput is 1 instr/cycle with instr_ready held 1 and FIFO_DEPTH ≥ 2.
- Stall: with instr_ready=0, the FIFO fills and issue stops. No instruction is lost or duplicated, and the head stays stable while instr_valid=1 and instr_ready=0.
- Redirect (cycle N):
  - FIFO flushed and the in-flight read dropped.
  - fetch_pc<=redirect_pc, so pc=redirect_pc in cycle N+1.
  - instr_valid=0 in N+1. First valid instruction is from redirect_pc in N+3 at the earliest.
  - Redirect overrides a simultaneous pop: the head is not consumed.
- Redirect and reset together: reset wins.
- Reset mid-stall or mid-fetch returns to the reset state; the in-flight word is dropped.
- run=0: no issue, fetch_pc holds, and the FIFO drains normally. Reasserting run resumes at the held fetch_pc.
- Simultaneous push and pop: both occur, and count is unchanged.

Optional Feature:
- Macro FETCH_EARLY_JMP_EN.
- Defined:
  - A returned word with instr_in[15:10]==JMP_OPCODE that is pushed also sets fetch_pc<=instr_in[9:0], and sets discard for the word issued in the same cycle (the sequential successor).
  - The JMP word itself is still pushed to decode.
  - An external redirect in the same cycle takes priority.
- Not defined:
  - JMP words are treated as ordinary instructions; fetch continues sequentially until redirect_valid.
  - The discard logic is absent or tied to 0.

Test Plan:
- Reset, run=1, instr_ready=1, bench ROM returns mem[pc] → pc sequence 0,1,2,3; instr_pc 0,1,2 on consecutive cycles from cycle 2 after reset; no gaps.
- instr_ready=0 for 6 cycles after first valid → head holds {instr_pc=0}; pc stops advancing once count+inflight=FIFO_DEPTH. On release, instr_pc 0,1,2,… delivered in order with no duplicates.
- At steady state, redirect_valid=1 with redirect_pc=10'h003 in cycle N → instr_valid=0 in N+1, pc=3 in N+1, first instr_pc=3 in N+3; no pre-redirect word appears afterwards.
- fetch_pc set to 10'h3FE via redirect → instr_pc sequence 3FE, 3FF, 000, 001.
- Redirect coincident with pop, and reset asserted mid-stall → head not consumed and FIFO flushed; reset gives pc=RESET_PC, instr_valid=0, instr_out=0 next cycle.
- FETCH_EARLY_JMP_EN defined, ROM word at 5 = {JMP_OPCODE, 10'd3} → delivered instr_pc sequence 3,4,5,3,4,5 with no instr_pc=6. Without the macro, instr_pc=6 follows 5.
